mod_if_fetch: RTL
=================

# mod_if_fetch

Instruction-fetch stage of the 16-bit pipelined CPU: owns the program counter, issues requests to instruction memory, and loads the IF/ID pipeline register that feeds the decode stage. It is the producer end of the decode stage's `instruction`/`pc` inputs and the consumer of decode's `taken`/`new_pc`/`halt` redirect outputs. Handles variable-latency memory responses, hazard stalls, branch squash and HLT stop.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `stall`  in  1  hazard unit: hold PC and IF/ID
- `taken`  in  1  decode: branch/jump redirect this cycle
- `new_pc`  in  16  decode: redirect target
- `imem_req`  out  1  fetch request, one-cycle pulse
- `imem_addr`  out  16  fetch address (= `pc`)
- `imem_valid`  in  1  response strobe, ≥1 cycle after `imem_req`
- `imem_data`  in  16  response instruction
- `if_id_instr`  out  16  instruction to decode
- `if_id_pc`  out  16  fetch address + 2, to decode
- `if_id_valid`  out  1  IF/ID holds a real instruction
- `halted`  out  1  HLT fetched; fetch stopped

## Operation
- State: `pc`[15:0], FSM {FETCH, WAIT, HOLD, HALTED}, `squash` flag, skid buffer `buf`[15:0].
- Redirect = `taken & ~stall`. `taken` is ignored while `stall`=1.
- Bubble: `if_id_valid`=0, `if_id_instr`=16'h0000 (ADD R0,R0,R0), `if_id_pc` unchanged.
- Capture(x): `if_id_instr`<=x, `if_id_pc`<=`pc`+2, `if_id_valid`<=1; `pc`<=`pc`+2 unless x[15:12]=4'hF.
- IF/ID holds all fields whenever `stall`=1; otherwise it captures or loads a bubble every cycle.
- FETCH: `imem_req`=1, `imem_addr`=`pc`; next WAIT. Redirect: `pc`<=`new_pc`, `squash`<=1.
- WAIT, `imem_valid`=0: redirect → `pc`<=`new_pc`, `squash`<=1; stay WAIT.
- WAIT, `imem_valid`=1:
  - `squash`=1 or redirect: discard response; `squash`<=0; FETCH (`pc`<=`new_pc` on redirect).
  - `stall`=1: `buf`<=`imem_data`; HOLD.
  - else Capture(`imem_data`); HLT → HALTED, else FETCH.
- HOLD: `stall`=1 → stay. Redirect → drop `buf`, `pc`<=`new_pc`, FETCH. Else Capture(`buf`); HLT → HALTED, else FETCH.
- HALTED: `imem_req`=0 permanently, `halted`=1, `pc` frozen at HLT address; exit only on `rst`.
- `pc` arithmetic modulo 2^16: 16'hFFFE+2 = 16'h0000. `new_pc` is taken verbatim.
- Response when FSM is not in WAIT is a protocol violation: ignored.

## Timing
- Reset (`rst` high at edge): `pc`=16'h0000, FETCH, `squash`=0, `buf`=0, IF/ID = bubble with `if_id_pc`=16'h0000, `halted`=0; `imem_req`=1 in the first cycle after reset deasserts.
- `imem_req`, `imem_addr`, `halted` are Moore outputs (state/`pc` only).
- Zero-wait memory (`imem_valid` the cycle after `imem_req`): one instruction per 2 cycles; FETCH→WAIT→FETCH.
- Response with N-cycle latency: captured in IF/ID at the edge ending the `imem_valid` cycle.
- Redirect cost: redirect edge → `imem_req` at `new_pc` in the next FETCH (1 cycle if in WAIT with response, otherwise after the squashed response drains).
- `rst` mid-WAIT: outstanding response is not tracked; memory must drop it on reset.

## Test plan
- Reset, zero-wait memory returning 16'h1234 at 0x0000, 16'h5678 at 0x0002 → `imem_addr` 0x0000, 0x0002, 0x0004; IF/ID gets (1234, pc 0x0002, valid) then (5678, 0x0004).
- 3-cycle latency memory with `stall`=1 across response → `buf` holds data, IF/ID unchanged; on `stall`=0, IF/ID gets data next edge, `pc`+=2.
- `taken`=1, `new_pc`=0x0100 while WAIT outstanding → late response discarded, bubble in IF/ID, next `imem_addr`=0x0100.
- `taken`=1 with `stall`=1 → no redirect, `pc` and IF/ID unchanged.
- Fetch 16'hF000 at 0x0006 → IF/ID=F000/0x0008 valid, `halted`=1, `imem_req` stays 0 for 20 cycles, then bubbles into IF/ID; `rst` restarts at 0x0000.
- `pc`=0xFFFE, fetch 16'h1111 → `if_id_pc`=0x0000, next `imem_addr`=0x0000.

Source files
------------

// File: rtl/mod_if_fetch.sv
// Instruction-fetch stage: owns the PC, issues one request at a time to
// instruction memory and loads the IF/ID register feeding decode.
module mod_if_fetch (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        taken_i,
  input  logic [15:0] new_pc_i,
  output logic        imem_req_o,
  output logic [15:0] imem_addr_o,
  input  logic        imem_valid_i,
  input  logic [15:0] imem_data_i,
  output logic [15:0] if_id_instr_o,
  output logic [15:0] if_id_pc_o,
  output logic        if_id_valid_o,
  output logic        halted_o
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_HALTED
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        squash_q, squash_d;
  logic [15:0] buf_q, buf_d;
  logic [15:0] if_id_instr_q, if_id_instr_d;
  logic [15:0] if_id_pc_q, if_id_pc_d;
  logic        if_id_valid_q, if_id_valid_d;

  logic        redirect;
  logic        capture;
  logic [15:0] cap_instr;
  logic [15:0] pc_plus2;

  assign redirect = taken_i & ~stall_i;
  assign pc_plus2 = pc_q + 16'd2;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    squash_d  = squash_q;
    buf_d     = buf_q;
    capture   = 1'b0;
    cap_instr = buf_q;

    case (state_q)
      S_FETCH: begin
        state_d = S_WAIT;
        if (redirect) begin
          pc_d     = new_pc_i;
          squash_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (!imem_valid_i) begin
          if (redirect) begin
            pc_d     = new_pc_i;
            squash_d = 1'b1;
          end
        end else if (squash_q || redirect) begin
          // Stale or now-unwanted response: drop it and refetch.
          squash_d = 1'b0;
          state_d  = S_FETCH;
          if (redirect) pc_d = new_pc_i;
        end else if (stall_i) begin
          buf_d   = imem_data_i;
          state_d = S_HOLD;
        end else begin
          capture   = 1'b1;
          cap_instr = imem_data_i;
        end
      end
      S_HOLD: begin
        if (stall_i) begin
          state_d = S_HOLD;
        end else if (redirect) begin
          pc_d    = new_pc_i;
          state_d = S_FETCH;
        end else begin
          capture   = 1'b1;
          cap_instr = buf_q;
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_FETCH;
    endcase

    if (capture) begin
      if (cap_instr[15:12] == 4'hF) begin
        state_d = S_HALTED;
      end else begin
        pc_d    = pc_plus2;
        state_d = S_FETCH;
      end
    end
  end

  always_comb begin
    if_id_instr_d = if_id_instr_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_valid_d = if_id_valid_q;
    if (!stall_i) begin
      if (capture) begin
        if_id_instr_d = cap_instr;
        if_id_pc_d    = pc_plus2;
        if_id_valid_d = 1'b1;
      end else begin
        if_id_instr_d = 16'h0000;
        if_id_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_FETCH;
      pc_q          <= 16'h0000;
      squash_q      <= 1'b0;
      buf_q         <= 16'h0000;
      if_id_instr_q <= 16'h0000;
      if_id_pc_q    <= 16'h0000;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      squash_q      <= squash_d;
      buf_q         <= buf_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  assign imem_req_o    = (state_q == S_FETCH);
  assign imem_addr_o   = pc_q;
  assign halted_o      = (state_q == S_HALTED);
  assign if_id_instr_o = if_id_instr_q;
  assign if_id_pc_o    = if_id_pc_q;
  assign if_id_valid_o = if_id_valid_q;

endmodule
